// File: rtl/add_in_responder_pkg.sv
// Shared types and default sizing for the add_in responder slice.
// Defaults are kept aligned with add_in_pkg_hdl.
package add_in_responder_pkg;

    localparam int ADD_WIDTH_DEFAULT = 4;
    localparam int DEPTH_DEFAULT     = 4;
    localparam int PTR_W             = $clog2(DEPTH_DEFAULT);

    typedef logic [ADD_WIDTH_DEFAULT-1:0] operand_t;
    typedef logic [ADD_WIDTH_DEFAULT:0]   result_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

endpackage

// File: rtl/add_in_responder_fifo.sv
// Generic show-ahead FIFO: dout always reflects the head entry.
// The occupancy state (EMPTY/PARTIAL/FULL) is tracked alongside the count.
module add_in_responder_fifo
    import add_in_responder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT + 1,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    occ_state_t       state;
    occ_state_t       state_next;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push    = push && (state != OCC_FULL);
        do_pop     = pop && (state != OCC_EMPTY);
        cnt_next   = cnt;
        state_next = state;
        if (do_push && !do_pop) begin
            cnt_next = cnt + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_next = cnt - CW'(1);
        end
        if (cnt_next == '0) begin
            state_next = OCC_EMPTY;
        end else if (cnt_next == CW'(DEPTH)) begin
            state_next = OCC_FULL;
        end else begin
            state_next = OCC_PARTIAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            state  <= OCC_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (state == OCC_FULL);
    assign empty = (state == OCC_EMPTY);
    assign count = cnt;

endmodule

// File: rtl/add_in_responder.sv
// Responder end of the add_in bus: adds a+b and queues sums for the add_out side.
// Optional ADD_IN_RESPONDER_STATS_EN adds txn_count and ovf_seen outputs.
module add_in_responder
    import add_in_responder_pkg::*;
#(
    parameter int ADD_WIDTH = ADD_WIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADD_WIDTH-1:0]   a,
    input  logic [ADD_WIDTH-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADD_WIDTH:0]     out_sum,
    output logic [$clog2(DEPTH):0] count
`ifdef ADD_IN_RESPONDER_STATS_EN
    ,
    output logic [15:0]            txn_count,
    output logic                   ovf_seen
`endif
);

    logic               alive;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ADD_WIDTH:0] sum;
    logic [ADD_WIDTH:0] head;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign sum       = {1'b0, a} + {1'b0, b};
    assign in_ready  = alive && !full;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_sum   = out_valid ? head : '0;

    add_in_responder_fifo #(
        .WIDTH (ADD_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sum),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef ADD_IN_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
            ovf_seen  <= 1'b0;
        end else if (pop) begin
            txn_count <= txn_count + 16'd1;
            if (head[ADD_WIDTH]) begin
                ovf_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_in_responder.sv
// Scoreboard bench for add_in_responder (ADD_WIDTH=4, DEPTH=4).
// Expected sums are hand-computed and queued at input acceptance; a monitor pops on output.
module tb_add_in_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic [2:0] count;
`ifdef ADD_IN_RESPONDER_STATS_EN
    logic [15:0] txn_count;
    logic        ovf_seen;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] cur_exp;
    logic [4:0] exp_q[$];

    add_in_responder #(
        .ADD_WIDTH (4),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .count     (count)
`ifdef ADD_IN_RESPONDER_STATS_EN
        ,
        .txn_count (txn_count),
        .ovf_seen  (ovf_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until the handshake edge.
    task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] ve);
        int n = 0;
        a        = va;
        b        = vb;
        cur_exp  = ve;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (count != 3'd0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // Acceptance tracker: queue the expectation on the handshake edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(cur_exp);
    end

    // Monitor: compare the head whenever it is about to be popped.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", out_sum);
            end else begin
                chk("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cur_exp   = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Single add with one-cycle latency.
        out_ready = 1'b1;
        send(4'h3, 4'h5, 5'h08);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sum", 32'(out_sum), 32'h08);
        chk("single_count", 32'(count), 32'd1);
        tick();
        chk("single_count_after_pop", 32'(count), 32'd0);
        chk("single_valid_after_pop", 32'(out_valid), 32'd0);
`ifdef ADD_IN_RESPONDER_STATS_EN
        chk("ovf_before_carry", 32'(ovf_seen), 32'd0);
`endif

        // Carry into the MSB.
        send(4'hF, 4'h1, 5'h10);
        send(4'hF, 4'hF, 5'h1E);
        drain();
`ifdef ADD_IN_RESPONDER_STATS_EN
        chk("ovf_seen", 32'(ovf_seen), 32'd1);
        chk("txn_count", 32'(txn_count), 32'd3);
`endif

        // Fill under backpressure; a fifth pair must wait.
        out_ready = 1'b0;
        send(4'h1, 4'h1, 5'h02);
        send(4'h2, 4'h2, 5'h04);
        send(4'h3, 4'h3, 5'h06);
        send(4'h4, 4'h4, 5'h08);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_sum_held", 32'(out_sum), 32'h02);
        a        = 4'h5;
        b        = 4'h5;
        cur_exp  = 5'h0A;
        in_valid = 1'b1;
        tick();
        tick();
        chk("held_not_accepted", 32'(count), 32'd4);
        chk("held_sum_stable", 32'(out_sum), 32'h02);
        out_ready = 1'b1;
        tick();
        chk("first_pop_count", 32'(count), 32'd3);
        chk("first_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("push_pop_after_full", 32'(count), 32'd3);
        in_valid = 1'b0;
        drain();

        // Simultaneous push and pop at count=2.
        out_ready = 1'b0;
        send(4'h1, 4'h2, 5'h03);
        send(4'h2, 4'h3, 5'h05);
        chk("pp_start_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        send(4'h3, 4'h4, 5'h07);
        chk("pp_count_1", 32'(count), 32'd2);
        send(4'h4, 4'h5, 5'h09);
        chk("pp_count_2", 32'(count), 32'd2);
        send(4'h5, 4'h6, 5'h0B);
        chk("pp_count_3", 32'(count), 32'd2);
        drain();

        // Reset with three results queued, then a fresh push.
        out_ready = 1'b0;
        send(4'h1, 4'h0, 5'h01);
        send(4'h2, 4'h0, 5'h02);
        send(4'h3, 4'h0, 5'h03);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_sum", 32'(out_sum), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(4'h7, 4'h8, 5'h0F);
        chk("post_rst_sum", 32'(out_sum), 32'h0F);
        drain();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
